// File: rtl/ac_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | ac_ctrl_pkg : shared constants and types for the AC sequencer      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package ac_ctrl_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_REG = 3'b111;

   localparam logic [11:0] RR_CLA = 12'h800;
   localparam logic [11:0] RR_CLE = 12'h400;
   localparam logic [11:0] RR_CMA = 12'h200;
   localparam logic [11:0] RR_CME = 12'h100;
   localparam logic [11:0] RR_CIR = 12'h080;
   localparam logic [11:0] RR_CIL = 12'h040;
   localparam logic [11:0] RR_INC = 12'h020;
   localparam logic [11:0] RR_SPA = 12'h010;
   localparam logic [11:0] RR_SNA = 12'h008;
   localparam logic [11:0] RR_SZA = 12'h004;
   localparam logic [11:0] RR_SZE = 12'h002;
   localparam logic [11:0] RR_SKIP_MASK = 12'h01E;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DECODE  = 3'd1;
   localparam logic [2:0] ST_INDIR   = 3'd2;
   localparam logic [2:0] ST_OPFETCH = 3'd3;
   localparam logic [2:0] ST_EXEC    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_DECODE  = ST_DECODE,
      S_INDIR   = ST_INDIR,
      S_OPFETCH = ST_OPFETCH,
      S_EXEC    = ST_EXEC,
      S_DONE    = ST_DONE
   } state_e;

   typedef struct packed {
      logic ld;
      logic clr;
      logic inr;
      logic and_op;
      logic add_op;
      logic cma;
      logic cme;
      logic cir;
      logic cil;
      logic cle;
   } strobe_t;

   typedef struct packed {
      logic    is_mem;
      logic    is_reg;
      logic    indirect;
      strobe_t strobe;
      logic    is_skip;
      logic    illegal;
   } dec_t;

   function automatic logic onehot11(input logic [10:0] v);
      return (v != 11'd0) && ((v & (v - 11'd1)) == 11'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ac_ctrl_decode.sv
// +------------------------------------------------------------------+
// | ac_ctrl_decode : combinational IR decode (skip bits legal only    |
// | with AC_CTRL_SKIP_EN).  Rev 1.0                                    |
// +------------------------------------------------------------------+
`default_nettype none

module ac_ctrl_decode
   import ac_ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);

   logic unused_ir0;
   assign unused_ir0 = ir[0];

   always_comb begin
      dec = '0;
      case (ir[14:12])
         OP_AND, OP_ADD, OP_LDA: begin
            dec.is_mem   = 1'b1;
            dec.indirect = ir[15];
         end
         OP_REG: begin
            if (!ir[15] && onehot11(ir[11:1])) dec.is_reg  = 1'b1;
            else                               dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase

      if (dec.is_mem) begin
         dec.strobe.and_op = (ir[14:12] == OP_AND);
         dec.strobe.add_op = (ir[14:12] == OP_ADD);
         dec.strobe.ld     = (ir[14:12] == OP_LDA);
      end

      if (dec.is_reg) begin
         dec.strobe.clr = |(ir[11:0] & RR_CLA);
         dec.strobe.cle = |(ir[11:0] & RR_CLE);
         dec.strobe.cma = |(ir[11:0] & RR_CMA);
         dec.strobe.cme = |(ir[11:0] & RR_CME);
         dec.strobe.cir = |(ir[11:0] & RR_CIR);
         dec.strobe.cil = |(ir[11:0] & RR_CIL);
         dec.strobe.inr = |(ir[11:0] & RR_INC);
         dec.is_skip    = |(ir[11:0] & RR_SKIP_MASK);
`ifndef AC_CTRL_SKIP_EN
         if (dec.is_skip) begin
            dec.is_reg  = 1'b0;
            dec.is_skip = 1'b0;
            dec.illegal = 1'b1;
         end
`endif
      end
   end

endmodule

`default_nettype wire

// File: rtl/ac_ctrl_seq.sv
// +------------------------------------------------------------------+
// | ac_ctrl_seq : instruction sequencer for the AC/E datapath;        |
// | AC_CTRL_SKIP_EN enables skip instructions.  Rev 1.0               |
// +------------------------------------------------------------------+
`default_nettype none

module ac_ctrl_seq
   import ac_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dr_ld,
   output logic              ac_ld,
   output logic              ac_clr,
   output logic              ac_inr,
   output logic              ac_and,
   output logic              ac_add,
   output logic              ac_cma,
   output logic              ac_cme,
   output logic              ac_cir,
   output logic              ac_cil,
   output logic              ac_cle,
   input  logic [DATA_W-1:0] ac_in,
   input  logic              e_in,
   output logic              skip,
   output logic              done,
   output logic              ill
);

   localparam int unsigned TMO_LIM  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [15:0] TMO_LAST = TMO_LIM[15:0];

   state_e            state_q, state_d;
   logic [15:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       tmo_q, tmo_d;
   logic              instr_ready_q, instr_ready_d;
   logic              mem_req_q, mem_req_d;
   strobe_t           strobe_q, strobe_d;
   logic              done_q, done_d;
   logic              ill_q, ill_d;
   logic              skip_q, skip_d;
   logic              dr_ld_w;
   logic              tmo_hit;
   dec_t              dec;
   logic              unused_bits;

   ac_ctrl_decode u_decode (
      .ir  (ir_q),
      .dec (dec)
   );

   assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      addr_d   = addr_q;
      tmo_d    = tmo_q;
      strobe_d = '0;
      ill_d    = 1'b0;
      skip_d   = 1'b0;
      dr_ld_w  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               ir_d    = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec.is_mem) begin
               addr_d  = ADDR_W'(ir_q[11:0]);
               tmo_d   = '0;
               state_d = dec.indirect ? S_INDIR : S_OPFETCH;
            end else if (dec.is_reg) begin
               strobe_d = dec.strobe;
               state_d  = S_EXEC;
            end else begin
               ill_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_INDIR: begin
            // An ack on the last allowed cycle still wins over the timeout.
            if (mem_ack) begin
               addr_d  = mem_rdata[ADDR_W-1:0];
               tmo_d   = '0;
               state_d = S_OPFETCH;
            end else if (tmo_hit) begin
               ill_d   = 1'b1;
               state_d = S_DONE;
            end else if (MEM_TIMEOUT != 0) begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_OPFETCH: begin
            if (mem_ack) begin
               dr_ld_w  = 1'b1;
               strobe_d = dec.strobe;
               state_d  = S_EXEC;
            end else if (tmo_hit) begin
               ill_d   = 1'b1;
               state_d = S_DONE;
            end else if (MEM_TIMEOUT != 0) begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_EXEC: begin
`ifdef AC_CTRL_SKIP_EN
            skip_d = dec.is_skip &
                     ((|(ir_q[11:0] & RR_SPA) & ~ac_in[15]) |
                      (|(ir_q[11:0] & RR_SNA) &  ac_in[15]) |
                      (|(ir_q[11:0] & RR_SZA) & (ac_in == '0)) |
                      (|(ir_q[11:0] & RR_SZE) & ~e_in));
`endif
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      instr_ready_d = (state_d == S_IDLE);
      mem_req_d     = (state_d == S_INDIR) || (state_d == S_OPFETCH);
      done_d        = (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q       <= S_IDLE;
         ir_q          <= '0;
         addr_q        <= '0;
         tmo_q         <= '0;
         instr_ready_q <= 1'b1;
         mem_req_q     <= 1'b0;
         strobe_q      <= '0;
         done_q        <= 1'b0;
         ill_q         <= 1'b0;
         skip_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         addr_q        <= addr_d;
         tmo_q         <= tmo_d;
         instr_ready_q <= instr_ready_d;
         mem_req_q     <= mem_req_d;
         strobe_q      <= strobe_d;
         done_q        <= done_d;
         ill_q         <= ill_d;
         skip_q        <= skip_d;
      end
   end

`ifdef AC_CTRL_SKIP_EN
   assign skip        = skip_q;
   assign unused_bits = ^{mem_rdata[DATA_W-1:ADDR_W]};
`else
   assign skip        = 1'b0;
   assign unused_bits = ^{mem_rdata[DATA_W-1:ADDR_W], ac_in, e_in, dec.is_skip, skip_q};
`endif

   assign instr_ready = instr_ready_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = addr_q;
   assign dr_ld       = dr_ld_w;
   assign done        = done_q;
   assign ill         = ill_q;
   assign ac_ld       = strobe_q.ld;
   assign ac_clr      = strobe_q.clr;
   assign ac_inr      = strobe_q.inr;
   assign ac_and      = strobe_q.and_op;
   assign ac_add      = strobe_q.add_op;
   assign ac_cma      = strobe_q.cma;
   assign ac_cme      = strobe_q.cme;
   assign ac_cir      = strobe_q.cir;
   assign ac_cil      = strobe_q.cil;
   assign ac_cle      = strobe_q.cle;

endmodule

`default_nettype wire

// File: tb/tb_ac_ctrl_seq.sv
// +------------------------------------------------------------------+
// | tb_ac_ctrl_seq : directed + random bench for ac_ctrl_seq          |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ac_ctrl_seq;

   logic        CLK, RSTn, instr_valid, mem_ack, e_in;
   logic [15:0] instr, mem_rdata, ac_in;
   logic        instr_ready, mem_req, dr_ld, skip, done, ill;
   logic [11:0] mem_addr;
   logic        ac_ld, ac_clr, ac_inr, ac_and, ac_add, ac_cma, ac_cme, ac_cir, ac_cil, ac_cle;
   logic [9:0]  stb;

   int tests = 0;
   int fails = 0;

   ac_ctrl_seq #(.ADDR_W(12), .DATA_W(16), .MEM_TIMEOUT(4)) dut (
      .CLK(CLK), .RSTn(RSTn), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .dr_ld(dr_ld), .ac_ld(ac_ld), .ac_clr(ac_clr),
      .ac_inr(ac_inr), .ac_and(ac_and), .ac_add(ac_add), .ac_cma(ac_cma),
      .ac_cme(ac_cme), .ac_cir(ac_cir), .ac_cil(ac_cil), .ac_cle(ac_cle),
      .ac_in(ac_in), .e_in(e_in), .skip(skip), .done(done), .ill(ill)
   );

   // Strobe vector order: ld clr inr and add cma cme cir cil cle
   assign stb = {ac_ld, ac_clr, ac_inr, ac_and, ac_add, ac_cma, ac_cme, ac_cir, ac_cil, ac_cle};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: what the instruction word means, straight from the ISA description.
   function automatic void model(input logic [15:0] w, input logic [15:0] ac, input logic e,
                                 output bit bad, output bit mem, output bit ind,
                                 output logic [9:0] vec, output bit skp);
      logic [2:0] opc;
      int         pos;
      int         ones;
      bit         skip_en;
`ifdef AC_CTRL_SKIP_EN
      skip_en = 1;
`else
      skip_en = 0;
`endif
      opc = w[14:12];
      bad = 0; mem = 0; ind = 0; vec = '0; skp = 0;
      ones = 0; pos = 0;
      for (int b = 1; b < 12; b++) if (w[b]) begin ones++; pos = b; end
      if (opc <= 3'd2) begin
         mem = 1;
         ind = w[15];
         vec = (opc == 3'd0) ? 10'h040 : (opc == 3'd1) ? 10'h020 : 10'h200;
      end else if (opc == 3'd7 && !w[15] && ones == 1) begin
         case (pos)
            11: vec = 10'h100;
            10: vec = 10'h001;
            9:  vec = 10'h010;
            8:  vec = 10'h008;
            7:  vec = 10'h004;
            6:  vec = 10'h002;
            5:  vec = 10'h080;
            4:  skp = !ac[15];
            3:  skp = ac[15];
            2:  skp = (ac == 16'd0);
            default: skp = !e;
         endcase
         if (pos <= 4 && !skip_en) begin bad = 1; skp = 0; end
      end else begin
         bad = 1;
      end
   endfunction

   // One full instruction: offer, serve reads with given waits/data, then check EXEC and DONE.
   task automatic run(input logic [15:0] w, input int wt0, input int wt1,
                      input logic [15:0] d0, input logic [15:0] d1, input bit no_ack,
                      input logic [15:0] ac, input logic e);
      bit          bad, mem, ind, skp, timed_out, ack_now, last;
      logic [9:0]  vec;
      logic [11:0] addr;
      logic [15:0] dat;
      int          nrd, n, wt;
      model(w, ac, e, bad, mem, ind, vec, skp);
      ac_in = ac; e_in = e;
      timed_out = 0;
      chk("idle_ready", instr_ready, 1);
      instr = w; instr_valid = 1'b1;
      tick();
      // Busy: valid/instr garbage and a stray ack must be ignored
      instr_valid = 1'($urandom_range(0, 1));
      instr = 16'($urandom);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      chk("dec_quiet", {mem_req, done, instr_ready, stb}, 0);
      #1 chk("dec_drld", dr_ld, 0);
      tick();
      instr_valid = 1'b0; mem_ack = 1'b0;
      if (!bad && mem) begin
         addr = w[11:0];
         nrd = ind ? 2 : 1;
         for (int r = 0; r < nrd; r++) begin
            wt = (r == 0) ? wt0 : wt1;
            dat = (r == 0) ? d0 : d1;
            last = (r == nrd - 1);
            n = (no_ack && r == 0) ? 4 : wt + 1;
            for (int i = 0; i < n; i++) begin
               chk("req_hi", mem_req, 1);
               chk("req_addr", mem_addr, addr);
               chk("req_quiet", {done, stb}, 0);
               ack_now = !(no_ack && r == 0) && (i == wt);
               mem_ack = ack_now;
               mem_rdata = ack_now ? dat : 16'($urandom);
               #1 chk("dr_ld", dr_ld, ack_now && last);
               tick();
               mem_ack = 1'b0;
            end
            if (no_ack && r == 0) begin timed_out = 1; break; end
            addr = dat[11:0];
         end
      end
      if (!bad && !timed_out) begin
         chk("exec_stb", stb, vec);
         chk("exec_quiet", {mem_req, done, instr_ready}, 0);
         tick();
      end
      chk("done", done, 1);
      chk("done_ill", ill, bad || timed_out);
      chk("done_skip", skip, skp && !timed_out);
      chk("done_quiet", {mem_req, stb}, 0);
      tick();
      chk("back_idle", {instr_ready, done}, 2'b10);
   endtask

   initial begin
      logic [15:0] w, ac;
      logic [2:0]  opc;
      RSTn = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0;
      mem_rdata = '0; ac_in = '0; e_in = 1'b0;
      tick(); tick();
      chk("rst_ready", instr_ready, 1);
      chk("rst_outs", {mem_req, done, ill, skip, stb}, 0);
      chk("rst_addr", mem_addr, 0);
      RSTn = 1'b1;
      tick();

      run(16'h7200, 0, 0, 16'h0, 16'h0, 0, 16'h1234, 1'b0);   // CMA
      run(16'h1123, 2, 0, 16'h0005, 16'h0, 0, 16'h0, 1'b0);   // direct ADD
      run(16'hA050, 0, 1, 16'h0300, 16'hBEEF, 0, 16'h0, 1'b0); // indirect LDA
      run(16'h7300, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1'b0);
      run(16'h3000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1'b0);
      run(16'hF800, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1'b0);
      run(16'h0010, 0, 0, 16'h0, 16'h0, 1, 16'h0, 1'b0);      // timeout
      run(16'h8020, 0, 0, 16'h0, 16'h0, 1, 16'h0, 1'b0);      // timeout on indirect read
      run(16'h7004, 0, 0, 16'h0, 16'h0, 0, 16'h0000, 1'b1);   // SZA, AC=0
      run(16'h7004, 0, 0, 16'h0, 16'h0, 0, 16'h0040, 1'b1);   // SZA, AC!=0
      run(16'h0777, 3, 0, 16'h1111, 16'h0, 0, 16'h0, 1'b0);   // ack on last allowed cycle

      // Reset in the middle of an operand fetch
      instr = 16'h1456; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("pre_rst_req", mem_req, 1);
      RSTn = 1'b0;
      tick();
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_ready", instr_ready, 1);
      chk("rst_mid_outs", {done, ill, stb}, 0);
      RSTn = 1'b1;
      tick();
      chk("rst_mid_idle", {instr_ready, mem_req}, 2'b10);

      for (int k = 0; k < 80; k++) begin
         opc = 3'($urandom_range(0, 7));
         w = {1'($urandom_range(0, 1)), opc, 12'($urandom)};
         if (opc == 3'd7 && $urandom_range(0, 3) != 0) begin
            w[11:0] = (12'd1 << $urandom_range(1, 11)) | 12'($urandom_range(0, 1));
            w[15] = ($urandom_range(0, 7) == 0);
         end
         case ($urandom_range(0, 2))
            0:       ac = 16'h0000;
            1:       ac = 16'h8000 | 16'($urandom);
            default: ac = 16'($urandom) & 16'h7FFF;
         endcase
         run(w, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 9) == 0), ac, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
